// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
package ps2_pkg;

  // Frame sequencer states: wait for start bit, eight data bits, parity, stop.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // Prefix bytes that modify the following scan code instead of being events.
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // One decoded key event as held in the output register.
  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } ps2_event_t;

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises the raw PS/2 clock and data lines into the clk domain and
// produces a registered one-cycle pulse on each falling edge of the PS/2
// clock, with the data line delayed to line up with that pulse.
module ps2_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic res,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic                   clk_prev_reg;
  logic                   fall_reg;
  logic                   data_reg;

  // Synchroniser chains; reset to the idle-high bus level so that leaving
  // reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (res) begin
      clk_sync_reg  <= '1;
      data_sync_reg <= '1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
      data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Falling-edge detect, registered together with the data sample so both
  // arrive in the same cycle.
  always_ff @(posedge clk) begin
    if (res) begin
      clk_prev_reg <= 1'b1;
      fall_reg     <= 1'b0;
      data_reg     <= 1'b1;
    end else begin
      clk_prev_reg <= clk_sync_reg[SYNC_STAGES-1];
      fall_reg     <= clk_prev_reg & ~clk_sync_reg[SYNC_STAGES-1];
      data_reg     <= data_sync_reg[SYNC_STAGES-1];
    end
  end

  assign fall   = fall_reg;
  assign data_s = data_reg;

endmodule

// File: rtl/ps2_rx_ctrl.sv
// PS/2 keyboard frame receiver: frames 11-bit packets, checks start/parity/
// stop, folds E0/F0 prefixes into a single key event and offers it through a
// single-entry valid/ready output register.
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_break,
  output logic       ev_ext,
  output logic       err_parity,
  output logic       err_frame,
  output logic       err_overflow
);

  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic            fall;
  logic            data_s;
  ps2_state_t      state_reg, state_next;
  logic [2:0]      cnt_reg;
  logic [7:0]      byte_reg;
  logic            parity_reg;
  logic [TO_W-1:0] to_cnt_reg;
  logic            break_pend_reg, ext_pend_reg;
  logic            ev_valid_reg;
  ps2_event_t      ev_reg;
  logic            err_parity_reg, err_frame_reg, err_overflow_reg;

  logic timeout, frame_done, good, set_break, set_ext, new_ev;
  logic set_err_frame, set_err_parity, pop;

  ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .res     (res),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .fall    (fall),
    .data_s  (data_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (res) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next state: advance on PS/2 falling edges, bail to IDLE on timeout.
  always_comb begin
    state_next = state_reg;
    if (timeout) begin
      state_next = IDLE;
    end else if (fall) begin
      case (state_reg)
        IDLE:    if (!data_s) state_next = DATA;
        DATA:    if (cnt_reg == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Frame verdict and event/error decisions for the current cycle.
  always_comb begin
    timeout        = (state_reg != IDLE) && !fall && (to_cnt_reg == TO_LAST);
    frame_done     = (state_reg == STOP) && fall;
    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    good           = frame_done && data_s && (^{byte_reg, parity_reg});
    set_err_frame  = timeout || (frame_done && !data_s);
    set_err_parity = frame_done && data_s && !(^{byte_reg, parity_reg});
    set_break      = good && (byte_reg == PS2_BREAK);
    set_ext        = good && (byte_reg == PS2_EXT);
    new_ev         = good && !set_break && !set_ext;
    pop            = ev_valid_reg && ev_ready;
  end

  // Frame datapath: bit counter, byte shifter, parity latch, timeout counter.
  always_ff @(posedge clk) begin
    if (res) begin
      cnt_reg    <= 3'd0;
      byte_reg   <= 8'd0;
      parity_reg <= 1'b0;
      to_cnt_reg <= '0;
    end else begin
      if (state_reg == IDLE) cnt_reg <= 3'd0;
      else if (state_reg == DATA && fall) begin
        byte_reg[cnt_reg] <= data_s;
        cnt_reg           <= cnt_reg + 3'd1;
      end
      if (state_reg == PARITY && fall) parity_reg <= data_s;
      if (state_reg == IDLE || fall) to_cnt_reg <= '0;
      else                           to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

  // Prefix flags, error pulses and the single-entry output register.
  always_ff @(posedge clk) begin
    if (res) begin
      break_pend_reg   <= 1'b0;
      ext_pend_reg     <= 1'b0;
      err_parity_reg   <= 1'b0;
      err_frame_reg    <= 1'b0;
      err_overflow_reg <= 1'b0;
      ev_valid_reg     <= 1'b0;
      ev_reg           <= '0;
    end else begin
      err_parity_reg   <= set_err_parity;
      err_frame_reg    <= set_err_frame;
      err_overflow_reg <= new_ev && ev_valid_reg && !ev_ready;
      if (set_err_frame || set_err_parity || new_ev) begin
        break_pend_reg <= 1'b0;
        ext_pend_reg   <= 1'b0;
      end else begin
        if (set_break) break_pend_reg <= 1'b1;
        if (set_ext)   ext_pend_reg   <= 1'b1;
      end
      // A full, non-popping register keeps the old event and drops the new.
      if (new_ev && (!ev_valid_reg || pop)) begin
        ev_valid_reg <= 1'b1;
        ev_reg       <= '{code: byte_reg, brk: break_pend_reg, ext: ext_pend_reg};
      end else if (pop) begin
        ev_valid_reg <= 1'b0;
      end
    end
  end

  assign ev_valid     = ev_valid_reg;
  assign ev_code      = ev_valid_reg ? ev_reg.code : 8'd0;
  assign ev_break     = ev_valid_reg & ev_reg.brk;
  assign ev_ext       = ev_valid_reg & ev_reg.ext;
  assign err_parity   = err_parity_reg;
  assign err_frame    = err_frame_reg;
  assign err_overflow = err_overflow_reg;

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Scoreboard bench for ps2_rx_ctrl: directed PS/2 frames push expected
// events; a monitor pops and compares on every accepted event.
module tb_ps2_rx_ctrl;
  import ps2_pkg::*;

  localparam int TO_CYC = 200;
  localparam int HALF   = 10;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ev_valid;
  logic       ev_ready = 1'b1;
  logic [7:0] ev_code;
  logic       ev_break, ev_ext;
  logic       err_parity, err_frame, err_overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int act_par = 0, act_frm = 0, act_ovf = 0;
  int exp_par = 0, exp_frm = 0, exp_ovf = 0;
  logic valid_q = 1'b0;
  ps2_event_t sb[$];

  ps2_rx_ctrl #(.SYNC_STAGES(2), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk         (clk),
    .res         (res),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_code     (ev_code),
    .ev_break    (ev_break),
    .ev_ext      (ev_ext),
    .err_parity  (err_parity),
    .err_frame   (err_frame),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Monitor: scoreboard pops on handshake, latency on rise, pulse counting.
  always @(negedge clk) begin
    if (!res) begin
      if (err_parity)   act_par++;
      if (err_frame)    act_frm++;
      if (err_overflow) act_ovf++;
      if (ev_valid && !valid_q) check("ev_latency", cyc - stop_cyc, 4);
      if (ev_valid && ev_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ev_unexpected actual=%0h required=none", ev_code);
        end else begin
          ps2_event_t e;
          e = sb.pop_front();
          check("ev_code", ev_code, e.code);
          check("ev_break", ev_break, e.brk);
          check("ev_ext", ev_ext, e.ext);
        end
      end
      valid_q <= ev_valid;
    end else begin
      valid_q <= 1'b0;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send the first n bits of frame f (bit 0 = start bit) on the bus.
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p);
    send_bits({1'b1, p, b, 1'b0}, 11);
    wait_cyc(4 * HALF);
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic brk, input logic ext);
    sb.push_back('{code: code, brk: brk, ext: ext});
  endtask

  task automatic check_errs();
    check("err_parity_count", act_par, exp_par);
    check("err_frame_count", act_frm, exp_frm);
    check("err_overflow_count", act_ovf, exp_ovf);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ev_valid"}, ev_valid, 0);
    check({tag, "_ev_code"}, ev_code, 0);
    check({tag, "_flags"}, {ev_break, ev_ext, err_parity, err_frame, err_overflow}, 0);
  endtask

  initial begin
    wait_cyc(3);
    check_outputs_zero("reset");
    res = 1'b0;
    wait_cyc(10);

    // Make code 0x1C.
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check_errs();

    // Release: F0 then 1C.
    expect_ev(8'h1C, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1);
    send_frame(8'h1C, 1'b0);

    // Extended release: E0 F0 75, then plain 1C.
    expect_ev(8'h75, 1'b1, 1'b1);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b1);
    send_frame(8'h75, 1'b0);
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check_errs();

    // Parity error, then a good frame.
    exp_par++;
    send_frame(8'h1C, 1'b1);
    check_errs();
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0);

    // Timeout after start bit plus four data bits.
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 5);
    exp_frm++;
    wait_cyc(2 * TO_CYC);
    check_errs();
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0);

    // Backpressure: second event dropped with an overflow pulse.
    ev_ready = 1'b0;
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0);
    exp_ovf++;
    send_frame(8'h32, 1'b0);
    check("hold_ev_valid", ev_valid, 1);
    check("hold_ev_code", ev_code, 8'h1C);
    check_errs();
    ev_ready = 1'b1;
    wait_cyc(5);
    check("popped_ev_valid", ev_valid, 0);

    // Reset in the middle of a frame.
    send_bits({1'b1, 1'b0, 8'h32, 1'b0}, 4);
    res = 1'b1;
    wait_cyc(2);
    check_outputs_zero("midreset");
    res = 1'b0;
    wait_cyc(40);
    check_errs();
    expect_ev(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0);

    wait_cyc(20);
    check("sb_drained", sb.size(), 0);
    check_errs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
